// File: rtl/decoder_scan_sequencer_pkg.sv
// decoder_scan_sequencer_pkg: shared state encoding and line-count constants.
package decoder_scan_sequencer_pkg;
    localparam int NUM_LINES = 8;
    localparam int SEL_W = 3;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACTIVE = 3'd2,
        GAP    = 3'd3,
        DONE   = 3'd4
    } state_e;
endpackage

// File: rtl/decoder_scan_sequencer_if.sv
// decoder_scan_sequencer_if: control inputs and decoder-drive outputs of the scan sequencer.
interface decoder_scan_sequencer_if import decoder_scan_sequencer_pkg::*; #(parameter int DWELL_W = 8);
    logic                 start;
    logic                 stop;
    logic                 continuous;
    logic [NUM_LINES-1:0] mask;
    logic [DWELL_W-1:0]   dwell;
    logic [SEL_W-1:0]     sel;
    logic                 enable;
    logic                 line_strobe;
    logic                 busy;
    logic                 done;
    modport master (output start, stop, continuous, mask, dwell,
                    input sel, enable, line_strobe, busy, done);
    modport slave (input start, stop, continuous, mask, dwell,
                   output sel, enable, line_strobe, busy, done);
endinterface

// File: rtl/decoder_scan_sequencer_next_unmasked_line.sv
// next_unmasked_line: ascending search for the next set mask bit after cur_i, optionally wrapping.
module next_unmasked_line import decoder_scan_sequencer_pkg::*; (
    input  logic [SEL_W-1:0]     cur_i,
    input  logic [NUM_LINES-1:0] mask_i,
    input  logic                 wrap_i,
    output logic [SEL_W-1:0]     nxt_o,
    output logic                 found_o
);
    logic [SEL_W:0] pos;
    // The final step (k = NUM_LINES) revisits cur_i itself, so a lone line can wrap onto itself.
    always_comb begin
        nxt_o = cur_i;
        found_o = 1'b0;
        pos = '0;
        for (int k = 1; k <= NUM_LINES; k++) begin
            pos = {1'b0, cur_i} + (SEL_W+1)'(k);
            if (!found_o && (wrap_i || !pos[SEL_W]) && mask_i[pos[SEL_W-1:0]]) begin
                found_o = 1'b1;
                nxt_o = pos[SEL_W-1:0];
            end
        end
    end
endmodule

// File: rtl/decoder_scan_sequencer.sv
// decoder_scan_sequencer: drives a 3-to-8 decoder's select/enable through unmasked lines with dwell and dead cycles.
module decoder_scan_sequencer import decoder_scan_sequencer_pkg::*; #(parameter int DWELL_W = 8) (
    input logic clk,
    input logic rst_n,
    decoder_scan_sequencer_if.slave scan
);
    state_e               state_q, state_d;
    logic [SEL_W-1:0]     sel_q, sel_d, cur, nxt;
    logic [NUM_LINES-1:0] mask_q, mask_d, srch_mask;
    logic [DWELL_W-1:0]   dwell_q, dwell_d, cnt_q, cnt_d;
    logic                 cont_q, cont_d, idle, wrap, found;
    logic                 enable_q, strobe_q, busy_q, done_q;
    // In IDLE the same searcher finds the lowest set bit of the incoming mask (start from top, wrap).
    assign idle = state_q == IDLE;
    assign cur = idle ? SEL_W'(NUM_LINES-1) : sel_q;
    assign srch_mask = idle ? scan.mask : mask_q;
    assign wrap = idle | cont_q;
    next_unmasked_line u_next (
        .cur_i(cur),
        .mask_i(srch_mask),
        .wrap_i(wrap),
        .nxt_o(nxt),
        .found_o(found)
    );
    always_comb begin
        state_d = state_q;
        sel_d = sel_q;
        mask_d = mask_q;
        dwell_d = dwell_q;
        cont_d = cont_q;
        cnt_d = cnt_q;
        case (state_q)
            IDLE: if (scan.start && !scan.stop) begin
                mask_d = scan.mask;
                dwell_d = scan.dwell;
                cont_d = scan.continuous;
                state_d = found ? SETUP : DONE;
                sel_d = found ? nxt : sel_q;
            end
            SETUP: begin
                state_d = scan.stop ? DONE : ACTIVE;
                cnt_d = dwell_q;
            end
            ACTIVE: begin
                state_d = scan.stop ? DONE : (cnt_q == '0 ? GAP : ACTIVE);
                cnt_d = cnt_q - 1'b1;
            end
            GAP: begin
                state_d = (scan.stop || !found) ? DONE : SETUP;
                sel_d = (!scan.stop && found) ? nxt : sel_q;
            end
            default: state_d = IDLE;
        endcase
    end
    // Outputs are flopped from next-state so they line up with state_q and never see inputs combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q <= '0;
            mask_q <= '0;
            dwell_q <= '0;
            cont_q <= 1'b0;
            cnt_q <= '0;
            enable_q <= 1'b0;
            strobe_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q <= sel_d;
            mask_q <= mask_d;
            dwell_q <= dwell_d;
            cont_q <= cont_d;
            cnt_q <= cnt_d;
            enable_q <= state_d == ACTIVE;
            strobe_q <= state_d == ACTIVE && state_q != ACTIVE;
            busy_q <= state_d != IDLE;
            done_q <= state_d == DONE;
        end
    end
    assign scan.sel = sel_q;
    assign scan.enable = enable_q;
    assign scan.line_strobe = strobe_q;
    assign scan.busy = busy_q;
    assign scan.done = done_q;
endmodule

// File: doc/decoder_scan_sequencer.md
Name: decoder_scan_sequencer

Overview:
- Sequential driver for the 3-to-8 decoder's select and enable inputs; sits directly upstream and feeds its A2..A0 and enable pins.
- Scans up to 8 lines in ascending order and holds each line active for a programmable dwell time.
- Skips lines that are masked off and inserts break-before-make dead cycles between lines.
- Supports one-shot and continuous (wrap-around) scanning, with start/stop control and busy/done status.

Parameters:
- DWELL_W, 8, width of the dwell input and the internal dwell counter.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin a scan; sampled only in IDLE.
- stop  input  1  abort request; honoured in any non-IDLE state.
- continuous  input  1  0 = one-shot pass, 1 = wrap and repeat until stop; latched at start.
- mask  input  8  bit k = 1 enables line k; latched at start.
- dwell  input  DWELL_W  active cycles per line minus 1; latched at start.
- sel  output  3  decoder select, {A2,A1,A0}.
- enable  output  1  decoder enable.
- line_strobe  output  1  one-cycle pulse on the first active cycle of each line.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a scan ends, whether completed or stopped.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; sel=0, enable=0, line_strobe=0, busy=0, done=0; latched mask, dwell and mode cleared; dwell counter=0.
- All outputs are registered; no combinational path from any input to any output.
- States: IDLE, SETUP, ACTIVE, GAP, DONE.
- IDLE:
  - start=1 and stop=0 at edge n: latch mask, dwell and continuous.
  - If latched mask≠0: go to SETUP with sel=lowest set mask bit.
  - If latched mask=0: go to DONE; enable never asserts.
  - start and stop both high: stay in IDLE; start is ignored.
- SETUP (1 cycle): enable=0, sel already holds the new line. Next state ACTIVE; load dwell counter with latched dwell.
- ACTIVE:
  - enable=1, sel held stable.
  - line_strobe=1 in the first ACTIVE cycle only.
  - Counter decrements each cycle. Exit when counter=0, so each line has exactly dwell+1 enable-high cycles (dwell=0 gives 1 cycle).
  - On exit go to GAP.
- GAP (1 cycle): enable=0, sel still holds the old line, so sel never changes while enable=1. On exit:
  - Next unmasked line above the current one exists: sel←that line, go to SETUP.
  - None above, continuous=1: sel←lowest unmasked line (wrap-around), go to SETUP.
  - None above, continuous=0: go to DONE; sel holds.
- DONE (1 cycle): done=1, enable=0, busy=1. Next state IDLE; sel holds its last value.
- Timing: with start sampled at edge n, SETUP occupies cycle n+1 and the first enable=1 cycle is n+2. Line period = dwell+3 cycles.
- Single unmasked line in continuous mode: repeats as ACTIVE, GAP, SETUP with the same sel value.
- stop=1 in SETUP, ACTIVE or GAP: next cycle is DONE with enable=0; the current line is truncated. stop in DONE is a no-op.
- start while busy: ignored, no effect on latched values.
- Changes to mask, dwell or continuous mid-scan: no effect until the next start.
- enable=1 only in ACTIVE, and exactly one line is active at a time. The decoder's one-hot output equals 1<<sel during ACTIVE and 0 otherwise.

Decomposition:
- Shared package/header:
  - state encoding localparams: IDLE=0, SETUP=1, ACTIVE=2, GAP=3, DONE=4 (3-bit);
  - NUM_LINES=8, SEL_W=3.
- Sub-module next_unmasked_line, purely combinational:
  - inputs: current sel[2:0], mask[7:0], wrap;
  - outputs: next sel[2:0] and found flag;
  - searches ascending from current+1, then wraps from 0 when wrap=1;
  - also serves the lowest-set-bit search at start (current=7, wrap=1).
- Top level holds the FSM, dwell counter and latches.

Test Plan:
- mask=8'hFF, dwell=0, continuous=0, start pulse:
  - sel visits 0..7, each with exactly 1 enable cycle and 2 dead cycles between lines;
  - 8 line_strobe pulses; done pulses once, 1 cycle after the GAP following line 7;
  - total busy cycles = 1+8×3 = 25.
- mask=8'b1010_0100, dwell=3, continuous=0:
  - sel sequence is 2, 5, 7; each has 4 enable cycles;
  - sel never changes while enable=1; lines 0, 1, 3, 4, 6 are never enabled.
- mask=8'h81, dwell=1, continuous=1, 3 full cycles then stop mid-ACTIVE on line 7:
  - sequence 0, 7, 0, 7, 0, 7 (wraps 7→0);
  - enable drops the cycle after stop; done pulses once; then IDLE.
- mask=8'h00, start: DONE on the next cycle, done pulses once, enable stays 0 throughout.
- Simultaneous start+stop in IDLE: busy stays 0. A second start during an active scan with a different mask: the scan continues with the original mask.
- Assert rst_n low asynchronously mid-ACTIVE (between clock edges):
  - enable, busy, sel go to 0 immediately, without waiting for a clock edge;
  - after release, a new start scans normally from the lowest unmasked line.
